// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state encodings plus
// a helper that tells whether an opcode needs the iterative mul/div unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLTU = 4'b0110,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1010,
    OP_REMU = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_adder.sv
// Parametrised ripple adder with carry-in and carry-out.
// Ports: a, b (DATA_W operands), cin (carry in) -> sum (DATA_W), cout.
module alu_adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           latch a/b and begin DATA_W iterations
//   is_div          1: divide, 0: multiply (sampled with start)
//   a, b            operands (multiplier/multiplicand or dividend/divisor)
//   done            one-cycle pulse after the last iteration
//   product_lo      low DATA_W bits of a*b
//   quotient        a / b  (all ones when b == 0)
//   remainder       a % b  (a when b == 0)
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product_lo,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic              busy_q;
  logic              done_q;
  logic              is_div_q;
  logic [CNT_W-1:0]  cnt_q;
  // opa: multiplier shifting right (mul) / dividend shifting out, quotient in (div)
  // opb: multiplicand shifting left (mul) / divisor (div)
  // acc: product accumulator (mul) / partial remainder (div)
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] acc_q;

  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   rem_diff;
  logic              take;
  logic [DATA_W-1:0] rem_next;

  // A zero divisor always "fits", which yields an all-ones quotient and a
  // remainder equal to the dividend without any special casing.
  assign rem_shift = {acc_q, opa_q[DATA_W-1]};
  assign rem_diff  = rem_shift - {1'b0, opb_q};
  assign take      = (rem_shift >= {1'b0, opb_q});
  assign rem_next  = take ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q   <= 1'b1;
        is_div_q <= is_div;
        cnt_q    <= '0;
        opa_q    <= a;
        opb_q    <= b;
        acc_q    <= '0;
      end else if (busy_q) begin
        if (is_div_q) begin
          opa_q <= {opa_q[DATA_W-2:0], take};
          acc_q <= rem_next;
        end else begin
          if (opa_q[0]) begin
            acc_q <= acc_q + opb_q;
          end
          opa_q <= opa_q >> 1;
          opb_q <= opb_q << 1;
        end
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done       = done_q;
  assign product_lo = acc_q;
  assign quotient   = opa_q;
  assign remainder  = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshake and registered result + NZCV.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     operation request / accept (ready only in IDLE)
//   a, b, control           operands and 4-bit opcode, latched on accept
//   out_valid / out_ready   result available (DONE) / consumer accepts
//   result, z, n, c, v      registered result and flags, stable in DONE
// Single-cycle ops spend one cycle with operands latched (in_ready low) before
// the result is registered; mul/div run DATA_W iterations in muldiv_iter.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              v
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;

  logic              accept;
  logic              md_start;
  logic              md_done;
  logic [DATA_W-1:0] md_prod, md_quo, md_rem, md_res;

  logic              sub_en;
  logic [DATA_W-1:0] add_b, sum;
  logic              cout, ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;

  logic              load;
  logic [DATA_W-1:0] load_val;
  logic              load_c, load_v;

  assign in_ready  = (state_q == ST_IDLE) && !pend_q;
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign md_start  = accept && is_multicycle(control);

  muldiv_iter #(.DATA_W(DATA_W)) u_muldiv (
    .clk        (clk),
    .rst        (reset),
    .start      (md_start),
    .is_div     (control != OP_MUL),
    .a          (a),
    .b          (b),
    .done       (md_done),
    .product_lo (md_prod),
    .quotient   (md_quo),
    .remainder  (md_rem)
  );

  always_comb begin
    md_res = md_quo;
    if (op_q == OP_MUL) begin
      md_res = md_prod;
    end else if (op_q == OP_REMU) begin
      md_res = md_rem;
    end
  end

  // Single adder: subtraction and both compares use a + ~b + 1.
  assign sub_en = (op_q == OP_SUB) || (op_q == OP_SLT) || (op_q == OP_SLTU);
  assign add_b  = sub_en ? ~b_q : b_q;

  alu_adder #(.DATA_W(DATA_W)) u_add (
    .a    (a_q),
    .b    (add_b),
    .cin  (sub_en),
    .sum  (sum),
    .cout (cout)
  );

  assign ovf = (a_q[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_c   = cout;
        alu_v   = ovf;
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ovf ^ sum[DATA_W-1]};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, ~cout};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    load     = 1'b0;
    load_val = '0;
    load_c   = 1'b0;
    load_v   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d   = 1'b0;
          state_d  = ST_DONE;
          load     = 1'b1;
          load_val = alu_res;
          load_c   = alu_c;
          load_v   = alu_v;
        end else if (accept) begin
          if (is_multicycle(control)) begin
            state_d = (control == OP_MUL) ? ST_MUL : ST_DIV;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (md_done) begin
          state_d  = ST_DONE;
          load     = 1'b1;
          load_val = md_res;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      result_d = load_val;
      z_d      = (load_val == '0);
      n_d      = load_val[DATA_W-1];
      c_d      = load_c;
      v_d      = load_v;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= control;
      end
    end
  end

  assign result = result_q;
  assign z      = z_q;
  assign n      = n_q;
  assign c      = c_q;
  assign v      = v_q;

endmodule
